acc_demo_window_accum: RTL and testbench

- Sits directly downstream of the ACC demo flag trim stage and consumes its trimmed flag (acc_demo_trim_flag).
- Accumulates PMT ADC samples over each high window of that flag.
- At each window close, emits one result record: sum, sample count, window index and overflow status.
- Windows that start before scan enable, or that contain too few samples, are never emitted.

---
 rtl/acc_demo_pkg.sv | 22 ++
 rtl/acc_sat_adder.sv | 55 +++++
 rtl/acc_demo_window_accum.sv | 140 ++++++++++++++
 tb/tb_acc_demo_window_accum.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_demo_pkg.sv
// Shared types and default widths for the ACC demo window accumulator.
package acc_demo_pkg;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefSumW  = 32;
  localparam int unsigned DefCntW  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StWaitLow,
    StArmed,
    StAccum
  } acc_state_e;

  typedef struct packed {
    logic [DefSumW-1:0] sum;
    logic [DefCntW-1:0] cnt;
    logic [DefCntW-1:0] idx;
    logic               ovf;
  } acc_result_t;

endpackage

// File: rtl/acc_sat_adder.sv
// Registered saturating accumulator with clear/load and a sticky overflow flag.
module acc_sat_adder #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SUM_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              add_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [SUM_W-1:0]  sum_o,
  output logic              ovf_o
);

  logic [SUM_W-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic [SUM_W:0]   wide;
  logic             sat;

  always_comb begin
    wide = {1'b0, sum_q} + (SUM_W + 1)'(data_i);
    sat  = wide[SUM_W];
  end

  // Clear wins over load, load wins over add.
  always_comb begin
    sum_d = sum_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      sum_d = '0;
      ovf_d = 1'b0;
    end else if (load_i) begin
      sum_d = SUM_W'(data_i);
      ovf_d = 1'b0;
    end else if (add_i) begin
      sum_d = sat ? '1 : wide[SUM_W-1:0];
      ovf_d = ovf_q | sat;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      ovf_q <= ovf_d;
    end
  end

  assign sum_o = sum_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/acc_demo_window_accum.sv
// Accumulates ADC samples over each high window of the trimmed ACC flag and
// emits one result record per qualifying window.
module acc_demo_window_accum
  import acc_demo_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned SUM_W  = DefSumW,
  parameter int unsigned CNT_W  = DefCntW
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              pmt_scan_en_i,
  input  logic              acc_demo_trim_flag_i,
  input  logic [DATA_W-1:0] adc_data_i,
  input  logic              adc_valid_i,
  input  logic [CNT_W-1:0]  acc_min_window_i,
  output logic [SUM_W-1:0]  acc_sum_o,
  output logic [CNT_W-1:0]  acc_sample_cnt_o,
  output logic [CNT_W-1:0]  acc_window_idx_o,
  output logic              acc_overflow_o,
  output logic              acc_vld_o,
  output logic [CNT_W-1:0]  acc_drop_cnt_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  acc_state_e       state_q, state_d;
  logic             flag_q, scan_en_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic rise, fall, scan_start;
  logic win_start, win_add, win_close, emit;
  logic sum_clr, sum_load;
  logic [SUM_W-1:0] sum;
  logic             ovf;

  always_comb begin
    rise       = ~flag_q & acc_demo_trim_flag_i;
    fall       = flag_q & ~acc_demo_trim_flag_i;
    scan_start = ~scan_en_q & pmt_scan_en_i;
    win_start  = pmt_scan_en_i & (state_q == StArmed) & rise;
    win_add    = pmt_scan_en_i & (state_q == StAccum) & acc_demo_trim_flag_i & adc_valid_i;
    win_close  = pmt_scan_en_i & (state_q == StAccum) & fall;
    emit       = win_close & (cnt_q >= acc_min_window_i);
    // Dropping scan enable discards any open window.
    sum_clr    = ~pmt_scan_en_i | (win_start & ~adc_valid_i);
    sum_load   = win_start & adc_valid_i;
  end

  always_comb begin
    state_d = state_q;
    if (!pmt_scan_en_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:    state_d = acc_demo_trim_flag_i ? StWaitLow : StArmed;
        StWaitLow: if (!acc_demo_trim_flag_i) state_d = StArmed;
        StArmed:   if (rise) state_d = StAccum;
        StAccum:   if (fall) state_d = StArmed;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    drop_d = drop_q;
    if (!pmt_scan_en_i) begin
      cnt_d = '0;
    end else if (win_start) begin
      cnt_d = CNT_W'(adc_valid_i);
    end else if (win_add && cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (scan_start) begin
      idx_d  = '0;
      drop_d = '0;
    end else if (emit) begin
      idx_d = idx_q + 1'b1;
    end else if (win_close && drop_q != CntMax) begin
      drop_d = drop_q + 1'b1;
    end
  end

  acc_sat_adder #(
    .DATA_W (DATA_W),
    .SUM_W  (SUM_W)
  ) u_sum (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (sum_clr),
    .load_i  (sum_load),
    .add_i   (win_add),
    .data_i  (adc_data_i),
    .sum_o   (sum),
    .ovf_o   (ovf)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      flag_q    <= 1'b0;
      scan_en_q <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      flag_q    <= acc_demo_trim_flag_i;
      scan_en_q <= pmt_scan_en_i;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      drop_q    <= drop_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_sum_o        <= '0;
      acc_sample_cnt_o <= '0;
      acc_window_idx_o <= '0;
      acc_overflow_o   <= 1'b0;
      acc_vld_o        <= 1'b0;
    end else begin
      acc_vld_o <= emit;
      if (emit) begin
        acc_sum_o        <= sum;
        acc_sample_cnt_o <= cnt_q;
        acc_window_idx_o <= idx_q;
        acc_overflow_o   <= ovf;
      end
    end
  end

  assign acc_drop_cnt_o = drop_q;

endmodule

// File: tb/tb_acc_demo_window_accum.sv
// Self-checking bench: window table, directed corner sequences and random traffic
// against a window-level reference model, on a 32-bit and an 18-bit sum instance.
module tb_acc_demo_window_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_en = 1'b0;
  logic        flag = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] data = '0;
  logic [15:0] min_win = '0;

  logic [31:0] a_sum;
  logic [15:0] a_cnt, a_idx, a_drop;
  logic        a_ovf, a_vld;
  logic [17:0] b_sum;
  logic [15:0] b_cnt, b_idx, b_drop;
  logic        b_ovf, b_vld;

  always #5 clk = ~clk;

  acc_demo_window_accum #(
    .DATA_W (16),
    .SUM_W  (32),
    .CNT_W  (16)
  ) dut_a (
    .clk_i                (clk),
    .rst_n_i              (rst_n),
    .pmt_scan_en_i        (scan_en),
    .acc_demo_trim_flag_i (flag),
    .adc_data_i           (data),
    .adc_valid_i          (valid),
    .acc_min_window_i     (min_win),
    .acc_sum_o            (a_sum),
    .acc_sample_cnt_o     (a_cnt),
    .acc_window_idx_o     (a_idx),
    .acc_overflow_o       (a_ovf),
    .acc_vld_o            (a_vld),
    .acc_drop_cnt_o       (a_drop)
  );

  acc_demo_window_accum #(
    .DATA_W (16),
    .SUM_W  (18),
    .CNT_W  (16)
  ) dut_b (
    .clk_i                (clk),
    .rst_n_i              (rst_n),
    .pmt_scan_en_i        (scan_en),
    .acc_demo_trim_flag_i (flag),
    .adc_data_i           (data),
    .adc_valid_i          (valid),
    .acc_min_window_i     (min_win),
    .acc_sum_o            (b_sum),
    .acc_sample_cnt_o     (b_cnt),
    .acc_window_idx_o     (b_idx),
    .acc_overflow_o       (b_ovf),
    .acc_vld_o            (b_vld),
    .acc_drop_cnt_o       (b_drop)
  );

  int checks = 0;
  int passes = 0;
  int vld_seen = 0;

  // Reference model: tracks windows, not FSM states.
  longint sum_max [2] = '{64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0003_FFFF};
  bit     m_scan_prev, m_flag_prev, m_blocked, m_in_win;
  longint m_sum [2];
  bit     m_ovf [2];
  int     m_cnt, m_idx, m_drop;
  bit     e_vld;
  longint e_sum [2];
  bit     e_ovf [2];
  int     e_cnt, e_idx;

  typedef struct {
    int          pre;
    int          high;
    bit          valid;
    logic [15:0] data;
    logic [15:0] min;
    int          exp_vld;
    longint      exp_sum;
    int          exp_cnt;
    int          exp_idx;
    int          exp_drop;
  } win_t;

  win_t tbl [8];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic model_reset();
    m_scan_prev = 0; m_flag_prev = 0; m_blocked = 0; m_in_win = 0;
    m_cnt = 0; m_idx = 0; m_drop = 0;
    e_vld = 0; e_cnt = 0; e_idx = 0;
    for (int k = 0; k < 2; k++) begin
      m_sum[k] = 0; m_ovf[k] = 0; e_sum[k] = 0; e_ovf[k] = 0;
    end
  endtask

  task automatic model_step();
    e_vld = 0;
    if (!scan_en) begin
      m_in_win = 0;
    end else if (!m_scan_prev) begin
      m_idx = 0; m_drop = 0; m_in_win = 0;
      m_blocked = flag;  // a window already open at scan start is ignored
    end else if (m_blocked) begin
      if (!flag) m_blocked = 0;
    end else if (!m_in_win) begin
      if (flag && !m_flag_prev) begin
        m_in_win = 1;
        m_cnt = valid ? 1 : 0;
        for (int k = 0; k < 2; k++) begin
          m_sum[k] = valid ? longint'(data) : 0;
          m_ovf[k] = 0;
        end
      end
    end else if (flag) begin
      if (valid) begin
        for (int k = 0; k < 2; k++) begin
          m_sum[k] += longint'(data);
          if (m_sum[k] > sum_max[k]) begin
            m_sum[k] = sum_max[k];
            m_ovf[k] = 1;
          end
        end
        if (m_cnt < 65535) m_cnt++;
      end
    end else begin
      m_in_win = 0;
      if (m_cnt >= int'(min_win)) begin
        e_vld = 1; e_cnt = m_cnt; e_idx = m_idx;
        for (int k = 0; k < 2; k++) begin
          e_sum[k] = m_sum[k]; e_ovf[k] = m_ovf[k];
        end
        m_idx = (m_idx + 1) % 65536;
      end else if (m_drop < 65535) begin
        m_drop++;
      end
    end
    m_scan_prev = scan_en;
    m_flag_prev = flag;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("vld", a_vld, e_vld);
    chk("sum", a_sum, e_sum[0]);
    chk("cnt", a_cnt, e_cnt);
    chk("idx", a_idx, e_idx);
    chk("ovf", a_ovf, e_ovf[0]);
    chk("drop", a_drop, m_drop);
    chk("b_vld", b_vld, e_vld);
    chk("b_sum", b_sum, e_sum[1]);
    chk("b_ovf", b_ovf, e_ovf[1]);
    if (a_vld) vld_seen++;
  endtask

  task automatic new_scan();
    scan_en = 0; flag = 0; valid = 0;
    tick(); tick();
    scan_en = 1;
    tick();
  endtask

  task automatic do_window(input win_t w, input string nm);
    int seen0;
    min_win = w.min; flag = 0; valid = 0;
    repeat (w.pre) tick();
    seen0 = vld_seen;
    flag = 1; valid = w.valid; data = w.data;
    repeat (w.high) tick();
    flag = 0; valid = 0;
    tick();
    chk({nm, "_vld_at_close"}, a_vld, w.exp_vld);
    chk({nm, "_vld_count"}, vld_seen - seen0, w.exp_vld);
    if (w.exp_vld != 0) begin
      chk({nm, "_sum"}, a_sum, w.exp_sum);
      chk({nm, "_cnt"}, a_cnt, w.exp_cnt);
      chk({nm, "_idx"}, a_idx, w.exp_idx);
    end
    chk({nm, "_drop"}, a_drop, w.exp_drop);
  endtask

  initial begin
    int seen0;
    int run_left;

    //         pre high v  data      min vld sum     cnt idx drop
    tbl[0] = '{0, 10, 1, 16'd100,   1, 1, 1000,   10, 0, 0};
    tbl[1] = '{2, 3,  1, 16'd5,     5, 0, 0,      0,  0, 1};
    tbl[2] = '{0, 6,  1, 16'd2,     5, 1, 12,     6,  1, 1};
    tbl[3] = '{0, 3,  1, 16'd9,     0, 1, 27,     3,  2, 1};
    tbl[4] = '{1, 2,  0, 16'd50,    0, 1, 0,      0,  3, 1};
    tbl[5] = '{3, 1,  1, 16'd40000, 1, 1, 40000,  1,  4, 1};
    tbl[6] = '{0, 4,  1, 16'hFFFF,  5, 0, 0,      0,  0, 2};
    tbl[7] = '{0, 5,  1, 16'hFFFF,  5, 1, 327675, 5,  5, 2};

    model_reset();
    @(posedge clk);
    #1;
    chk("reset_vld", a_vld, 0);
    chk("reset_sum", a_sum, 0);
    chk("reset_cnt", a_cnt, 0);
    chk("reset_idx", a_idx, 0);
    chk("reset_ovf", a_ovf, 0);
    chk("reset_drop", a_drop, 0);
    @(posedge clk);
    #3 rst_n = 1;

    // Window table within one scan; min changes between windows.
    new_scan();
    for (int i = 0; i < 8; i++) do_window(tbl[i], $sformatf("win%0d", i));

    // Flag already high at scan start: the partial window never counts.
    scan_en = 0; flag = 1; valid = 1; data = 16'd7; min_win = 16'd1;
    tick(); tick();
    scan_en = 1;
    seen0 = vld_seen;
    repeat (5) tick();
    flag = 0;
    repeat (3) tick();
    flag = 1;
    repeat (4) tick();
    flag = 0;
    tick();
    valid = 0;
    tick();
    chk("partial_vld_count", vld_seen - seen0, 1);
    chk("partial_sum", a_sum, 28);
    chk("partial_cnt", a_cnt, 4);
    chk("partial_idx", a_idx, 0);

    // Saturation on the 18-bit instance, then a clean window.
    new_scan();
    flag = 1; valid = 1; data = 16'hFFFF;
    repeat (8) tick();
    flag = 0; valid = 0;
    tick();
    chk("sat_b_sum", b_sum, 18'h3FFFF);
    chk("sat_b_ovf", b_ovf, 1);
    chk("sat_a_sum", a_sum, 524280);
    chk("sat_a_ovf", a_ovf, 0);
    flag = 1; valid = 1; data = 16'd1;
    repeat (2) tick();
    flag = 0; valid = 0;
    tick();
    chk("after_sat_b_ovf", b_ovf, 0);
    chk("after_sat_b_sum", b_sum, 2);
    chk("after_sat_b_idx", b_idx, 1);

    // Scan enable drops mid-window; min 0 would otherwise emit it.
    new_scan();
    min_win = 16'd0;
    flag = 1; valid = 1; data = 16'd5;
    repeat (4) tick();
    seen0 = vld_seen;
    scan_en = 0;
    tick(); tick();
    flag = 0;
    tick();
    scan_en = 1;
    tick();
    chk("abort_vld_count", vld_seen - seen0, 0);
    chk("abort_drop", a_drop, 0);
    flag = 1; data = 16'd3;
    repeat (2) tick();
    flag = 0; valid = 0;
    tick();
    chk("rescan_vld", a_vld, 1);
    chk("rescan_idx", a_idx, 0);
    chk("rescan_cnt", a_cnt, 2);
    chk("rescan_sum", a_sum, 6);

    // Asynchronous reset mid-window.
    min_win = 16'd1;
    flag = 1; valid = 1; data = 16'd10;
    repeat (3) tick();
    #2 rst_n = 0;
    #1;
    chk("arst_sum", a_sum, 0);
    chk("arst_cnt", a_cnt, 0);
    chk("arst_idx", a_idx, 0);
    chk("arst_ovf", a_ovf, 0);
    chk("arst_vld", a_vld, 0);
    chk("arst_drop", a_drop, 0);
    chk("arst_b_sum", b_sum, 0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1;
    flag = 0;
    seen0 = vld_seen;
    repeat (3) tick();
    chk("arst_no_vld", vld_seen - seen0, 0);
    flag = 1; data = 16'd10;
    repeat (4) tick();
    flag = 0; valid = 0;
    tick();
    chk("arst_fresh_vld", a_vld, 1);
    chk("arst_fresh_sum", a_sum, 40);
    chk("arst_fresh_idx", a_idx, 0);

    // Random traffic against the model.
    run_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (scan_en) begin
        if ($urandom_range(0, 149) == 0) scan_en = 0;
      end else if ($urandom_range(0, 3) == 0) begin
        scan_en = 1;
      end
      if (run_left == 0) begin
        flag = ~flag;
        run_left = flag ? $urandom_range(1, 12) : $urandom_range(1, 4);
      end
      run_left--;
      valid = ($urandom_range(0, 3) != 0);
      data = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      if ($urandom_range(0, 199) == 0) min_win = 16'($urandom_range(0, 6));
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
